// File: rtl/cpu_pkg.sv
// Shared processor definitions for the multiply/divide sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_WAIT  = 2'd2,
    MD_WB    = 2'd3
  } md_state_t;

  typedef enum logic {
    MD_OP_MULT = 1'b0,
    MD_OP_DIV  = 1'b1
  } md_op_t;

  localparam int unsigned MD_TIMEOUT     = 40;
  localparam int unsigned MD_CNT_W       = 6;
  localparam logic [4:0]  MD_STATUS_REG  = 5'd30;
  localparam int unsigned MD_CODE_MULT   = 4;
  localparam int unsigned MD_CODE_DIV    = 5;

  // Status value written on exception, selected by the failing operation.
  function automatic logic [31:0] md_status_code(input md_op_t op,
                                                 input int unsigned code_mult,
                                                 input int unsigned code_div);
    return (op == MD_OP_DIV) ? code_div : code_mult;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating cycle counter with synchronous clear and terminal-count flag.
module md_timeout_counter #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned TERMINAL = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count_q;

  // Clear has priority; counting stops at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Terminal count is a pure decode of the current value.
  always_comb begin
    tc = (count_q == WIDTH'(TERMINAL));
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences one iterative mult/div operation from issue to register write-back.
module multdiv_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT    = MD_TIMEOUT,
  parameter logic [4:0]  STATUS_REG = MD_STATUS_REG,
  parameter int unsigned CODE_MULT  = MD_CODE_MULT,
  parameter int unsigned CODE_DIV   = MD_CODE_DIV
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_ready,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        stall,
  output logic        busy,
  output logic        wb_req,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  input  logic        wb_grant
);

  md_state_t   state_q, state_d;
  md_op_t      op_q;
  logic [4:0]  rd_q;
  logic [31:0] a_q, b_q, result_q;
  logic        exc_q;
  logic        cnt_tc;
  logic        leave_wait;

  md_timeout_counter #(
    .WIDTH    (MD_CNT_W),
    .TERMINAL (TIMEOUT - 1)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == MD_START),
    .enable (state_q == MD_WAIT),
    .tc     (cnt_tc)
  );

  // WAIT ends on a unit result or on timeout; md_ready takes precedence.
  always_comb begin
    leave_wait = (state_q == MD_WAIT) && (md_ready || cnt_tc);
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, result and exception latches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= MD_OP_MULT;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      if ((state_q == MD_IDLE) && issue_valid) begin
        op_q <= md_op_t'(issue_op);
        rd_q <= issue_rd;
        a_q  <= issue_a;
        b_q  <= issue_b;
      end
      if (leave_wait) begin
        result_q <= md_result;
        exc_q    <= md_ready ? md_exception : 1'b1;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    wb_req        = 1'b0;
    wb_reg        = '0;
    wb_data       = '0;
    busy          = (state_q != MD_IDLE);
    stall         = issue_valid || busy;
    md_a          = a_q;
    md_b          = b_q;
    unique case (state_q)
      MD_IDLE: begin
        if (issue_valid) state_d = MD_START;
      end
      MD_START: begin
        md_start_mult = (op_q == MD_OP_MULT);
        md_start_div  = (op_q == MD_OP_DIV);
        state_d       = MD_WAIT;
      end
      MD_WAIT: begin
        // A clean result for r0 has nothing to write, so WB is bypassed.
        if (leave_wait) begin
          if (md_ready && !md_exception && (rd_q == '0)) state_d = MD_IDLE;
          else                                           state_d = MD_WB;
        end
      end
      MD_WB: begin
        wb_req  = 1'b1;
        wb_reg  = exc_q ? STATUS_REG : rd_q;
        wb_data = exc_q ? md_status_code(op_q, CODE_MULT, CODE_DIV) : result_q;
        if (wb_grant) state_d = MD_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized transaction-level bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  localparam int unsigned TMO = 40;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic        issue_op;
  logic [4:0]  issue_rd;
  logic [31:0] issue_a, issue_b;
  logic        md_start_mult, md_start_div;
  logic [31:0] md_a, md_b;
  logic        md_ready;
  logic [31:0] md_result;
  logic        md_exception;
  logic        stall, busy, wb_req;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_grant;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  multdiv_sequencer #(
    .TIMEOUT    (TMO),
    .STATUS_REG (5'd30),
    .CODE_MULT  (4),
    .CODE_DIV   (5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_op      (issue_op),
    .issue_rd      (issue_rd),
    .issue_a       (issue_a),
    .issue_b       (issue_b),
    .md_start_mult (md_start_mult),
    .md_start_div  (md_start_div),
    .md_a          (md_a),
    .md_b          (md_b),
    .md_ready      (md_ready),
    .md_result     (md_result),
    .md_exception  (md_exception),
    .stall         (stall),
    .busy          (busy),
    .wb_req        (wb_req),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .wb_grant      (wb_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Outputs that must all read zero while reset holds the block.
  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'({md_start_mult, md_start_div}), 32'd0);
    check({tag, "_md_a"}, md_a, 32'd0);
    check({tag, "_md_b"}, md_b, 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_wb_req"}, 32'(wb_req), 32'd0);
    check({tag, "_wb_reg"}, 32'(wb_reg), 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  // One full operation. The bench plays the iterative unit: md_ready is
  // presented in WAIT cycle 'lat' (counting from 0). Outcome is predicted
  // from the rules: result if ready arrives within TMO WAIT cycles, else a
  // status-code write; a clean r0 result writes nothing.
  task automatic run_txn(input logic op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b,
                         input int unsigned lat, input logic exc_in,
                         input int unsigned gdly, input logic junk);
    logic [31:0] res, exp_data;
    logic [4:0]  exp_reg;
    logic        exp_exc, exp_wb;
    int unsigned wait_cycles;

    res = op ? ((b == 0) ? 32'hFFFF_FFFF : a / b) : a * b;
    if (lat <= TMO - 1) begin
      exp_exc     = exc_in;
      wait_cycles = lat + 1;
    end else begin
      exp_exc     = 1'b1;
      wait_cycles = TMO;
    end
    exp_wb   = exp_exc || (rd != 5'd0);
    exp_reg  = exp_exc ? 5'd30 : rd;
    exp_data = exp_exc ? (op ? 32'd5 : 32'd4) : res;

    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rd    = rd;
    issue_a     = a;
    issue_b     = b;
    #1;
    check("issue_stall", 32'(stall), 32'd1);

    @(negedge clock);
    check("start_mult", 32'(md_start_mult), 32'(!op));
    check("start_div", 32'(md_start_div), 32'(op));
    check("start_md_a", md_a, a);
    check("start_md_b", md_b, b);
    check("start_busy", 32'(busy), 32'd1);
    issue_valid = 1'b0;

    for (int unsigned k = 0; k < wait_cycles; k++) begin
      @(negedge clock);
      check("wait_start", 32'({md_start_mult, md_start_div}), 32'd0);
      check("wait_wb_req", 32'(wb_req), 32'd0);
      check("wait_busy", 32'(busy), 32'd1);
      check("wait_md_a", md_a, a);
      check("wait_md_b", md_b, b);
      wb_grant    = 1'($urandom_range(0, 1));
      issue_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      issue_op    = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom);
      issue_a     = $urandom;
      issue_b     = $urandom;
      if (k == lat) begin
        md_ready     = 1'b1;
        md_result    = res;
        md_exception = exc_in;
      end else begin
        md_ready     = 1'b0;
        md_result    = $urandom;
        md_exception = 1'($urandom_range(0, 1));
      end
    end

    @(negedge clock);
    wb_grant     = 1'b0;
    md_ready     = junk;
    md_result    = $urandom;
    md_exception = 1'($urandom_range(0, 1));
    if (exp_wb) begin
      for (int unsigned g = 0; g <= gdly; g++) begin
        if (g > 0) @(negedge clock);
        check("wb_req", 32'(wb_req), 32'd1);
        check("wb_reg", 32'(wb_reg), 32'(exp_reg));
        check("wb_data", wb_data, exp_data);
        check("wb_start", 32'({md_start_mult, md_start_div}), 32'd0);
        check("wb_stall", 32'(stall), 32'd1);
        check("wb_md_a", md_a, a);
        issue_valid = junk;
        if (g == gdly) begin
          wb_grant    = 1'b1;
          issue_valid = 1'b0;
          md_ready    = 1'b0;
        end
      end
      @(negedge clock);
      wb_grant = 1'b0;
      check("post_grant_busy", 32'(busy), 32'd0);
      check("post_grant_wb_req", 32'(wb_req), 32'd0);
      check("post_grant_stall", 32'(stall), 32'd0);
    end else begin
      issue_valid = 1'b0;
      md_ready    = 1'b0;
      #1;
      check("skip_busy", 32'(busy), 32'd0);
      check("skip_wb_req", 32'(wb_req), 32'd0);
      check("skip_stall", 32'(stall), 32'd0);
    end
  endtask

  // Reset in the middle of WAIT, then a stale md_ready after release.
  task automatic reset_mid_wait();
    @(negedge clock);
    issue_valid = 1'b1;
    issue_op    = 1'b0;
    issue_rd    = 5'd7;
    issue_a     = 32'd11;
    issue_b     = 32'd13;
    @(negedge clock);
    issue_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clock);
    reset = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clock);
      check("post_rst_wb_req", 32'(wb_req), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_start", 32'({md_start_mult, md_start_div}), 32'd0);
      md_ready     = (k < 3);
      md_result    = 32'hDEAD_BEEF;
      md_exception = 1'b0;
    end
    md_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        op, exc_in;
    logic [4:0]  rd;
    logic [31:0] a, b;
    int unsigned lat;

    reset        = 1'b0;
    issue_valid  = 1'b0;
    issue_op     = 1'b0;
    issue_rd     = '0;
    issue_a      = '0;
    issue_b      = '0;
    md_ready     = 1'b0;
    md_result    = '0;
    md_exception = 1'b0;
    wb_grant     = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    run_txn(1'b0, 5'd3, 32'd7, 32'd6, 32, 1'b0, 0, 1'b0);       // 7 x 6 -> r3
    run_txn(1'b1, 5'd9, 32'd100, 32'd0, 5, 1'b1, 1, 1'b0);      // divide by zero
    run_txn(1'b0, 5'd12, 32'd5, 32'd5, 45, 1'b0, 0, 1'b0);      // timeout on mult
    run_txn(1'b1, 5'd17, 32'd1000, 32'd7, 3, 1'b0, 5, 1'b1);    // held grant + stray issue
    run_txn(1'b1, 5'd0, 32'd50, 32'd7, 4, 1'b0, 0, 1'b0);       // r0 skip
    run_txn(1'b0, 5'd5, 32'd3, 32'd3, TMO - 1, 1'b0, 0, 1'b0);  // ready ties with timeout
    run_txn(1'b0, 5'd0, 32'd3, 32'd3, TMO, 1'b0, 0, 1'b0);      // r0 but timed out
    run_txn(1'b0, 5'd4, 32'd9, 32'd9, 0, 1'b0, 0, 1'b0);        // minimum latency

    reset_mid_wait();
    run_txn(1'b0, 5'd8, 32'd12, 32'd12, 2, 1'b0, 0, 1'b0);

    for (int unsigned t = 0; t < 40; t++) begin
      op  = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      a   = $urandom;
      b   = (op && ($urandom_range(0, 3) == 0)) ? 32'd0 : $urandom;
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 4, TMO + 5)
                                        : $urandom_range(0, TMO - 1);
      exc_in = (op && (b == 0)) ? 1'b1 : ($urandom_range(0, 9) == 0);
      run_txn(op, rd, a, b, lat, exc_in, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum WAIT cycles before the unit declares a timeout.
REQ-002 Parameter STATUS_REG, default 5'd30: register written on exception.
REQ-003 Parameters CODE_MULT = 4 and CODE_DIV = 5: status values written to STATUS_REG.
REQ-004 One clock; reset is asynchronous and active-low. Ports are named clock and reset as elsewhere in the codebase.
REQ-005 clock  in  1  master clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low.
REQ-007 issue_valid  in  1  DX stage holds a mult or div.
REQ-008 issue_op  in  1  0 = mult, 1 = div.
REQ-009 issue_rd  in  5  destination register.
REQ-010 issue_a, issue_b  in  32 each  bypassed operands.
REQ-011 md_start_mult, md_start_div  out  1 each  one-cycle start pulses to the iterative unit.
REQ-012 md_a, md_b  out  32 each  latched operands, held stable from START until IDLE.
REQ-013 md_ready  in  1  unit result valid.
REQ-014 md_result  in  32  unit result.
REQ-015 md_exception  in  1  unit error flag (overflow or divide by zero).
REQ-016 stall  out  1  freezes PC/FD and bubbles DX.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 wb_req  out  1  requests the regfile write port.
REQ-019 wb_reg  out  5  register to write.
REQ-020 wb_data  out  32  data to write.
REQ-021 wb_grant  in  1  write port is free this cycle (MW stage not writing).

Function
REQ-022 States and transitions:
- IDLE -> START on issue_valid; latch op, rd, a and b on that edge.
- START -> WAIT unconditionally.
- WAIT -> WB when md_ready is high, or when the counter reaches TIMEOUT-1.
- WB -> IDLE on wb_grant.
REQ-023 In START, exactly one of md_start_mult/md_start_div is high for exactly one cycle, selected by the latched op. Both are low in every other state.
REQ-024 WAIT counter:
- cleared on entry to WAIT;
- increments each WAIT cycle;
- is 6 bits wide and saturates.
REQ-025 On leaving WAIT, latch the result register and an exception bit:
- exc = md_exception when md_ready; exc = 1 on timeout.
- md_ready and timeout in the same cycle: md_ready wins.
REQ-026 WB outputs without exception: wb_req = 1, wb_reg = latched rd, wb_data = latched result.
REQ-027 WB outputs with exception: wb_reg = STATUS_REG, wb_data = CODE_MULT or CODE_DIV zero-extended to 32 bits.
REQ-028 If latched rd = 0 and exc = 0, WB is skipped: WAIT goes directly to IDLE and wb_req never asserts.
REQ-029 stall = issue_valid OR busy, combinational. It deasserts in the cycle after wb_grant is accepted.
REQ-030 issue_valid in any state other than IDLE is ignored: no re-latch, no second start.
REQ-031 md_ready outside WAIT is ignored.
REQ-032 wb_req stays high with constant wb_reg and wb_data until wb_grant. wb_grant outside WB has no effect.
REQ-033 Latency: issue edge N gives the start pulse in cycle N+1. md_ready at edge M gives wb_req in cycle M+1. Minimum issue-to-IDLE time is 4 cycles with immediate grant.

Reset
REQ-034 Reset asserted at any time forces IDLE and clears all latches and the counter. All outputs read 0 (stall = 0 unless issue_valid is high).
REQ-035 An in-flight operation is discarded on reset; no write-back or start pulse occurs for it after reset releases.

Structure
REQ-036 The state encoding (IDLE = 0, START = 1, WAIT = 2, WB = 3) and the status codes are defined in the shared processor package (cpu_pkg).
REQ-037 A single sub-module, md_timeout_counter, implements the saturating counter with clear, enable and terminal-count output. Everything else stays flat.

Verification
REQ-038 Mult 7 x 6, rd = 3: single md_start_mult pulse; md_ready after 32 cycles -> wb_reg = 3, wb_data = 42; stall high from issue until the cycle after grant.
REQ-039 Div by zero, rd = 9: md_exception = 1 with md_ready -> wb_reg = 30, wb_data = 5.
REQ-040 No md_ready for 40 WAIT cycles on a mult -> wb_reg = 30, wb_data = 4.
REQ-041 wb_grant held low for 5 cycles in WB -> wb_req, wb_reg and wb_data stay constant; a second issue_valid during this time produces no start pulse.
REQ-042 rd = 0, no exception -> wb_req never asserts; busy falls the cycle after md_ready.
REQ-043 reset asserted during WAIT -> all outputs 0 immediately; a late md_ready after release produces no wb_req.
